sha1_round_ctrl: RTL and testbench



---
 rtl/sha1_round_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_sha1_round_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sha1_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sha1_round_ctrl
// Brief    : SHA-1 compression sequencer. Captures a 512-bit block on start,
//            runs 80 rounds at one round per clock, folds the result into
//            H0..H4 and presents the 160-bit digest with a done flag.
//            Optional cycle counter is enabled by defining SHA1_PERF_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sha1_round_ctrl #(
  parameter logic [31:0] IV_H0 = 32'h67452301,
  parameter logic [31:0] IV_H1 = 32'hEFCDAB89,
  parameter logic [31:0] IV_H2 = 32'h98BADCFE,
  parameter logic [31:0] IV_H3 = 32'h10325476,
  parameter logic [31:0] IV_H4 = 32'hC3D2E1F0
) (
  input  logic         wb_clk_i,
  input  logic         reset,
  input  logic         start,
  input  logic         init,
  input  logic         abort,
  input  logic [511:0] message,
  output logic         busy,
  output logic         done,
  output logic         panic,
  output logic [6:0]   loop_idx,
  output logic [159:0] digest
`ifdef SHA1_PERF_COUNT_EN
  ,
  output logic [31:0]  perf_cycles
`endif
);

  // Round constants, one per 20-round band
  localparam logic [31:0] c_K0 = 32'h5A827999;
  localparam logic [31:0] c_K1 = 32'h6ED9EBA1;
  localparam logic [31:0] c_K2 = 32'h8F1BBCDC;
  localparam logic [31:0] c_K3 = 32'hCA62C1D6;
  localparam logic [6:0]  c_LAST_ROUND = 7'd79;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_busy;
  logic        r_done;
  logic        r_panic;
  logic [6:0]  r_loop_idx;

  // Chaining state and working registers
  logic [31:0] r_h0, r_h1, r_h2, r_h3, r_h4;
  logic [31:0] r_a, r_b, r_c, r_d, r_e;

  // Schedule window: r_w[0] always holds W[t] for the round being executed,
  // r_w[1..15] hold W[t+1..t+15]. Each round appends W[t+16], so no
  // separate t<16 path is needed.
  logic [31:0] r_w [16];

  logic [31:0] w_msg_word [16];
  logic [31:0] w_f;
  logic [31:0] w_k;
  logic [31:0] w_tmp;
  logic [31:0] w_sched_x;
  logic [31:0] w_sched_next;

  // Slice the incoming block into its sixteen 32-bit words
  genvar gi;
  for (gi = 0; gi < 16; gi++) begin : g_msg_word
    assign w_msg_word[gi] = message[32*gi +: 32];
  end

  // Next schedule word W[t+16] = ROTL1(W[t+13]^W[t+8]^W[t+2]^W[t])
  assign w_sched_x    = r_w[13] ^ r_w[8] ^ r_w[2] ^ r_w[0];
  assign w_sched_next = {w_sched_x[30:0], w_sched_x[31]};

  // Round function and constant selected by the current round band
  always_comb begin
    w_f = 32'h0;
    w_k = 32'h0;
    if (r_loop_idx < 7'd20) begin
      w_f = (r_b & r_c) | (~r_b & r_d);
      w_k = c_K0;
    end else if (r_loop_idx < 7'd40) begin
      w_f = r_b ^ r_c ^ r_d;
      w_k = c_K1;
    end else if (r_loop_idx < 7'd60) begin
      w_f = (r_b & r_c) | (r_b & r_d) | (r_c & r_d);
      w_k = c_K2;
    end else begin
      w_f = r_b ^ r_c ^ r_d;
      w_k = c_K3;
    end
  end

  assign w_tmp = {r_a[26:0], r_a[31:27]} + w_f + r_e + w_k + r_w[0];

  // Sequencer: block capture, round iteration, chaining fold and status flags
  always_ff @(posedge wb_clk_i or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_panic    <= 1'b0;
      r_loop_idx <= 7'd0;
      r_h0       <= IV_H0;
      r_h1       <= IV_H1;
      r_h2       <= IV_H2;
      r_h3       <= IV_H3;
      r_h4       <= IV_H4;
      r_a        <= 32'h0;
      r_b        <= 32'h0;
      r_c        <= 32'h0;
      r_d        <= 32'h0;
      r_e        <= 32'h0;
      for (int i = 0; i < 16; i++) begin
        r_w[i] <= 32'h0;
      end
    end else if (abort) begin
      // Abort overrides everything, including a simultaneous start.
      // H is left alone so a chained retry resumes from the pre-block state.
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_panic    <= 1'b0;
      r_loop_idx <= 7'd0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            for (int i = 0; i < 16; i++) begin
              r_w[i] <= w_msg_word[i];
            end
            if (init) begin
              r_h0 <= IV_H0;
              r_h1 <= IV_H1;
              r_h2 <= IV_H2;
              r_h3 <= IV_H3;
              r_h4 <= IV_H4;
              r_a  <= IV_H0;
              r_b  <= IV_H1;
              r_c  <= IV_H2;
              r_d  <= IV_H3;
              r_e  <= IV_H4;
            end else begin
              r_a  <= r_h0;
              r_b  <= r_h1;
              r_c  <= r_h2;
              r_d  <= r_h3;
              r_e  <= r_h4;
            end
            r_done     <= 1'b0;
            r_busy     <= 1'b1;
            r_loop_idx <= 7'd0;
            r_state    <= ST_ROUND;
          end
        end

        ST_ROUND: begin
          if (start) begin
            r_panic <= 1'b1;
          end
          r_e <= r_d;
          r_d <= r_c;
          r_c <= {r_b[1:0], r_b[31:2]};
          r_b <= r_a;
          r_a <= w_tmp;
          for (int i = 0; i < 15; i++) begin
            r_w[i] <= r_w[i+1];
          end
          r_w[15] <= w_sched_next;
          if (r_loop_idx == c_LAST_ROUND) begin
            r_loop_idx <= 7'd0;
            r_state    <= ST_FINAL;
          end else begin
            r_loop_idx <= r_loop_idx + 7'd1;
          end
        end

        ST_FINAL: begin
          if (start) begin
            r_panic <= 1'b1;
          end
          r_h0    <= r_h0 + r_a;
          r_h1    <= r_h1 + r_b;
          r_h2    <= r_h2 + r_c;
          r_h3    <= r_h3 + r_d;
          r_h4    <= r_h4 + r_e;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign panic    = r_panic;
  assign loop_idx = r_loop_idx;
  assign digest   = {r_h4, r_h3, r_h2, r_h1, r_h0};

`ifdef SHA1_PERF_COUNT_EN
  logic [31:0] r_perf_cycles;

  // Saturating count of busy clocks; survives start, cleared by abort
  always_ff @(posedge wb_clk_i or posedge reset) begin
    if (reset) begin
      r_perf_cycles <= 32'h0;
    end else if (abort) begin
      r_perf_cycles <= 32'h0;
    end else if (r_busy && (r_perf_cycles != 32'hFFFFFFFF)) begin
      r_perf_cycles <= r_perf_cycles + 32'd1;
    end
  end

  assign perf_cycles = r_perf_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sha1_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha1_round_ctrl
// Brief    : Self-checking bench for sha1_round_ctrl using known SHA-1
//            digests, a vector table and hand-written corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha1_round_ctrl;

  logic         wb_clk_i = 1'b0;
  logic         reset    = 1'b1;
  logic         start    = 1'b0;
  logic         init     = 1'b0;
  logic         abort    = 1'b0;
  logic [511:0] message  = '0;
  logic         busy;
  logic         done;
  logic         panic;
  logic [6:0]   loop_idx;
  logic [159:0] digest;
`ifdef SHA1_PERF_COUNT_EN
  logic [31:0]  perf_cycles;
`endif

  sha1_round_ctrl dut (
    .wb_clk_i (wb_clk_i),
    .reset    (reset),
    .start    (start),
    .init     (init),
    .abort    (abort),
    .message  (message),
    .busy     (busy),
    .done     (done),
    .panic    (panic),
    .loop_idx (loop_idx),
    .digest   (digest)
`ifdef SHA1_PERF_COUNT_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  always #5 wb_clk_i = ~wb_clk_i;

  localparam logic [159:0] c_IV  = {32'hC3D2E1F0, 32'h10325476, 32'h98BADCFE, 32'hEFCDAB89, 32'h67452301};
  localparam logic [159:0] c_EMP = {32'hafd80709, 32'h95601890, 32'h3255bfef, 32'h5e6b4b0d, 32'hda39a3ee};
  localparam logic [159:0] c_ABC = {32'h9cd0d89d, 32'h7850c26c, 32'hba3e2571, 32'h4706816a, 32'ha9993e36};
  localparam logic [159:0] c_TWO = {32'he54670f1, 32'hf95129e5, 32'hbaae4aa1, 32'h1c3bd26e, 32'h84983e44};

  typedef struct {
    logic         init;
    logic [511:0] msg;
    logic         chk;
    logic [159:0] exp;
  } vec_t;

  vec_t vecs [5];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_start(input logic i_init, input logic [511:0] m);
    @(negedge wb_clk_i);
    start   = 1'b1;
    init    = i_init;
    message = m;
    @(negedge wb_clk_i);
    start   = 1'b0;
    init    = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge wb_clk_i);
    end
  endtask

  logic [511:0] m_emp, m_abc, m_b1, m_b2;
  logic [31:0]  b1_words [14];
  bit           ok;

  initial begin
    m_emp = '0;
    m_emp[31:0] = 32'h80000000;
    m_abc = '0;
    m_abc[31:0]    = 32'h61626380;
    m_abc[511:480] = 32'h00000018;
    b1_words = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                 32'h6d6e6f70, 32'h6e6f7071};
    m_b1 = '0;
    for (int t = 0; t < 14; t++) m_b1[32*t +: 32] = b1_words[t];
    m_b1[32*14 +: 32] = 32'h80000000;
    m_b2 = '0;
    m_b2[511:480] = 32'h000001C0;

    vecs[0] = '{init: 1'b1, msg: m_emp, chk: 1'b1, exp: c_EMP};
    vecs[1] = '{init: 1'b1, msg: m_abc, chk: 1'b1, exp: c_ABC};
    vecs[2] = '{init: 1'b1, msg: m_b1,  chk: 1'b0, exp: '0};
    vecs[3] = '{init: 1'b0, msg: m_b2,  chk: 1'b1, exp: c_TWO};
    vecs[4] = '{init: 1'b1, msg: m_emp, chk: 1'b1, exp: c_EMP};

    // Reset state
    repeat (2) @(negedge wb_clk_i);
    check("rst_busy",   {159'b0, busy},     160'd0);
    check("rst_done",   {159'b0, done},     160'd0);
    check("rst_panic",  {159'b0, panic},    160'd0);
    check("rst_loop",   {153'b0, loop_idx}, 160'd0);
    check("rst_digest", digest, c_IV);
    reset = 1'b0;

    // First block after reset with init=0 chains from IV
    do_start(1'b0, m_emp);
    wait_done(ok);
    check("first_init0_timeout", {159'b0, ok}, 160'd1);
    check("first_init0_digest", digest, c_EMP);
`ifdef SHA1_PERF_COUNT_EN
    check("perf_one_block", {128'b0, perf_cycles}, 160'd81);
`endif

    // Table of known-answer blocks
    for (int v = 0; v < 5; v++) begin
      do_start(vecs[v].init, vecs[v].msg);
      wait_done(ok);
      check($sformatf("vec%0d_done", v), {159'b0, ok}, 160'd1);
      if (vecs[v].chk) check($sformatf("vec%0d_digest", v), digest, vecs[v].exp);
    end

    // "abc" with loop_idx trace and completion timing
    do_start(1'b1, m_abc);
    for (int k = 0; k < 80; k++) begin
      check($sformatf("trace_loop%0d", k), {153'b0, loop_idx}, 160'(k));
      @(negedge wb_clk_i);
    end
    check("final_busy", {159'b0, busy},     160'd1);
    check("final_done", {159'b0, done},     160'd0);
    check("final_loop", {153'b0, loop_idx}, 160'd0);
    repeat (2) @(negedge wb_clk_i);
    check("trace_done", {159'b0, done}, 160'd1);
    check("trace_busy", {159'b0, busy}, 160'd0);
    check("trace_digest", digest, c_ABC);

    // Start while busy sets panic and leaves the run intact
    do_start(1'b1, m_abc);
    for (int i = 0; i < 100 && loop_idx != 7'd40; i++) @(negedge wb_clk_i);
    check("panic_reach40", {153'b0, loop_idx}, 160'd40);
    start = 1'b1; init = 1'b1; message = m_emp;
    @(negedge wb_clk_i);
    start = 1'b0; init = 1'b0;
    check("panic_set",  {159'b0, panic},    160'd1);
    check("panic_busy", {159'b0, busy},     160'd1);
    check("panic_loop", {153'b0, loop_idx}, 160'd41);
    wait_done(ok);
    check("panic_done", {159'b0, ok}, 160'd1);
    check("panic_digest", digest, c_ABC);
    check("panic_sticky", {159'b0, panic}, 160'd1);
    abort = 1'b1;
    @(negedge wb_clk_i);
    abort = 1'b0;
    check("abort_done",   {159'b0, done},  160'd0);
    check("abort_panic",  {159'b0, panic}, 160'd0);
    check("abort_busy",   {159'b0, busy},  160'd0);
    check("abort_digest", digest, c_ABC);

    // Abort mid-ROUND leaves H untouched
    do_start(1'b0, m_emp);
    repeat (30) @(negedge wb_clk_i);
    abort = 1'b1;
    @(negedge wb_clk_i);
    abort = 1'b0;
    check("midabort_busy",   {159'b0, busy},     160'd0);
    check("midabort_loop",   {153'b0, loop_idx}, 160'd0);
    check("midabort_digest", digest, c_ABC);

    // Start and abort together: abort wins, no IV load
    @(negedge wb_clk_i);
    start = 1'b1; abort = 1'b1; init = 1'b1; message = m_emp;
    @(negedge wb_clk_i);
    start = 1'b0; abort = 1'b0; init = 1'b0;
    check("both_busy",   {159'b0, busy},     160'd0);
    check("both_loop",   {153'b0, loop_idx}, 160'd0);
    check("both_digest", digest, c_ABC);

    // Asynchronous reset between edges during ROUND
    do_start(1'b0, m_abc);
    repeat (10) @(negedge wb_clk_i);
    #2 reset = 1'b1;
    #1;
    check("areset_busy",   {159'b0, busy},     160'd0);
    check("areset_done",   {159'b0, done},     160'd0);
    check("areset_loop",   {153'b0, loop_idx}, 160'd0);
    check("areset_digest", digest, c_IV);
    @(negedge wb_clk_i);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
